mouse_cursor_tracker: RTL and testbench

- Downstream consumer of the PS/2 mouse decoder (controlMouse).
- Takes the decoded per-packet direction flags (Izquierda/Derecha/Arriba/Abajo), magnitudes (MagX/MagY) and Click.
- Accumulates them into an absolute on-screen cursor position, bounded to the display area, for the VGA/game logic.
- Also produces single-cycle click and move event strobes.

---
 rtl/mouse_cursor_tracker.sv | 173 +++++++++++++++++
 tb/tb_mouse_cursor_tracker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor_tracker.sv
// Absolute cursor tracker fed by the PS/2 mouse decoder: clamps (or wraps when
// CURSOR_WRAP_EN is defined) the cursor to the display and emits click/move strobes.
module mouse_cursor_tracker #(
    parameter int unsigned POS_W  = 10,
    parameter int unsigned H_MAX  = 639,
    parameter int unsigned V_MAX  = 479,
    parameter int unsigned X_INIT = 320,
    parameter int unsigned Y_INIT = 240,
    parameter int unsigned SHIFT  = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PktValid,
    input  logic             Izquierda,
    input  logic             Derecha,
    input  logic             Arriba,
    input  logic             Abajo,
    input  logic [7:0]       MagX,
    input  logic [7:0]       MagY,
    input  logic             Click,
    output logic [POS_W-1:0] PosX,
    output logic [POS_W-1:0] PosY,
    output logic             ClickPulse,
    output logic             ClickHeld,
    output logic             Moved,
    output logic             Ready,
    output logic             Overrun
);

    typedef enum logic [1:0] {StIdle, StCalcX, StCalcY, StDone} state_e;

    localparam logic [POS_W:0]   HMax  = (POS_W+1)'(H_MAX);
    localparam logic [POS_W:0]   VMax  = (POS_W+1)'(V_MAX);
    localparam logic [POS_W-1:0] XInit = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] YInit = POS_W'(Y_INIT);

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_x_q, pos_x_d;
    logic [POS_W-1:0] pos_y_q, pos_y_d;
    logic [POS_W:0]   dx_q, dx_d;
    logic [POS_W:0]   dy_q, dy_d;
    logic             left_q, left_d;
    logic             right_q, right_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             click_held_q, click_held_d;
    logic             click_pulse_q, click_pulse_d;
    logic             moved_q, moved_d;
    logic             overrun_q, overrun_d;
    logic             ready_q, ready_d;

    // One axis update; sums are kept POS_W+1 wide so no carry is lost before the bound check.
    function automatic logic [POS_W-1:0] step_axis(
        input logic [POS_W-1:0] pos,
        input logic [POS_W:0]   d,
        input logic             inc,
        input logic             dec,
        input logic [POS_W:0]   lim
    );
        logic [POS_W:0] p;
        logic [POS_W:0] s;
        logic [POS_W:0] r;
        p = {1'b0, pos};
        s = p + d;
        r = p;
        if (inc && !dec) begin
`ifdef CURSOR_WRAP_EN
            r = (s > lim) ? s - (lim + 1'b1) : s;
`else
            r = (s > lim) ? lim : s;
`endif
        end else if (dec && !inc) begin
`ifdef CURSOR_WRAP_EN
            r = (d > p) ? p + (lim + 1'b1) - d : p - d;
`else
            r = (d > p) ? '0 : p - d;
`endif
        end
        return r[POS_W-1:0];
    endfunction

    always_comb begin
        state_d       = state_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        left_d        = left_q;
        right_d       = right_q;
        up_d          = up_q;
        down_d        = down_q;
        click_held_d  = click_held_q;
        click_pulse_d = 1'b0;
        moved_d       = 1'b0;
        overrun_d     = overrun_q | (PktValid & ~ready_q);

        unique case (state_q)
            StIdle: begin
                if (PktValid) begin
                    left_d        = Izquierda;
                    right_d       = Derecha;
                    up_d          = Arriba;
                    down_d        = Abajo;
                    dx_d          = (POS_W+1)'(MagX >> SHIFT);
                    dy_d          = (POS_W+1)'(MagY >> SHIFT);
                    click_pulse_d = Click & ~click_held_q;
                    click_held_d  = Click;
                    state_d       = StCalcX;
                end
            end
            StCalcX: begin
                pos_x_d = step_axis(pos_x_q, dx_q, right_q, left_q, HMax);
                state_d = StCalcY;
            end
            StCalcY: begin
                pos_y_d = step_axis(pos_y_q, dy_q, down_q, up_q, VMax);
                moved_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q       <= StIdle;
            pos_x_q       <= XInit;
            pos_y_q       <= YInit;
            dx_q          <= '0;
            dy_q          <= '0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            up_q          <= 1'b0;
            down_q        <= 1'b0;
            click_held_q  <= 1'b0;
            click_pulse_q <= 1'b0;
            moved_q       <= 1'b0;
            overrun_q     <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            left_q        <= left_d;
            right_q       <= right_d;
            up_q          <= up_d;
            down_q        <= down_d;
            click_held_q  <= click_held_d;
            click_pulse_q <= click_pulse_d;
            moved_q       <= moved_d;
            overrun_q     <= overrun_d;
            ready_q       <= ready_d;
        end
    end

    assign PosX       = pos_x_q;
    assign PosY       = pos_y_q;
    assign ClickPulse = click_pulse_q;
    assign ClickHeld  = click_held_q;
    assign Moved      = moved_q;
    assign Ready      = ready_q;
    assign Overrun    = overrun_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Self-checking bench for mouse_cursor_tracker; expectations follow CURSOR_WRAP_EN when defined.
module tb_mouse_cursor_tracker;

    typedef struct {
        logic       r;
        logic       l;
        logic       u;
        logic       d;
        logic [7:0] mx;
        logic [7:0] my;
        logic       click;
        int         ex;
        int         ey;
        logic       ep;
        logic       eh;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       PktValid = 1'b0;
    logic       pkt_valid1 = 1'b0;
    logic       Izquierda = 1'b0, Derecha = 1'b0, Arriba = 1'b0, Abajo = 1'b0;
    logic [7:0] MagX = '0, MagY = '0;
    logic       Click = 1'b0;

    logic [9:0] PosX, PosY;
    logic       ClickPulse, ClickHeld, Moved, Ready, Overrun;
    logic [9:0] PosX1, PosY1, PosX2, PosY2;
    logic       cp1, ch1, mv1, rd1, ov1, cp2, ch2, mv2, rd2, ov2;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always #5 Clk = ~Clk;

    mouse_cursor_tracker u_dut (
        .Clk(Clk), .Rst(Rst), .PktValid(PktValid), .Izquierda(Izquierda), .Derecha(Derecha),
        .Arriba(Arriba), .Abajo(Abajo), .MagX(MagX), .MagY(MagY), .Click(Click),
        .PosX(PosX), .PosY(PosY), .ClickPulse(ClickPulse), .ClickHeld(ClickHeld),
        .Moved(Moved), .Ready(Ready), .Overrun(Overrun)
    );

    mouse_cursor_tracker #(.SHIFT(2)) u_shift2 (
        .Clk(Clk), .Rst(Rst), .PktValid(pkt_valid1), .Izquierda(Izquierda), .Derecha(Derecha),
        .Arriba(Arriba), .Abajo(Abajo), .MagX(MagX), .MagY(MagY), .Click(Click),
        .PosX(PosX1), .PosY(PosY1), .ClickPulse(cp1), .ClickHeld(ch1),
        .Moved(mv1), .Ready(rd1), .Overrun(ov1)
    );

    mouse_cursor_tracker #(.SHIFT(7)) u_shift7 (
        .Clk(Clk), .Rst(Rst), .PktValid(pkt_valid1), .Izquierda(Izquierda), .Derecha(Derecha),
        .Arriba(Arriba), .Abajo(Abajo), .MagX(MagX), .MagY(MagY), .Click(Click),
        .PosX(PosX2), .PosY(PosY2), .ClickPulse(cp2), .ClickHeld(ch2),
        .Moved(mv2), .Ready(rd2), .Overrun(ov2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic l, input logic u, input logic d,
                                input int mx, input int my, input logic click,
                                input int ex, input int ey, input logic ep, input logic eh);
        vec_t v;
        v.r = r; v.l = l; v.u = u; v.d = d;
        v.mx = 8'(mx); v.my = 8'(my); v.click = click;
        v.ex = ex; v.ey = ey; v.ep = ep; v.eh = eh;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Derecha = v.r; Izquierda = v.l; Arriba = v.u; Abajo = v.d;
        MagX = v.mx; MagY = v.my; Click = v.click;
    endtask

    // Full packet: E0 capture, PosX at E1, PosY and Moved at E2, Ready back after E3.
    task automatic apply(input vec_t v);
        int n;
        vec_t e;
        @(negedge Clk);
        drive(v);
        PktValid = 1'b1;
        sb.push_back(v);
        @(posedge Clk); #1;
        PktValid = 1'b0;
        chk("ready_low_e0", Ready, 0);
        chk("click_pulse", ClickPulse, v.ep);
        chk("click_held", ClickHeld, v.eh);
        n = 0;
        while (!Moved && n < 8) begin
            @(posedge Clk); #1;
            n++;
            if (n == 1) begin
                chk("pulse_one_cycle", ClickPulse, 0);
                chk("posx_at_e1", PosX, v.ex);
            end
        end
        chk("moved_latency", n, 2);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("posx", PosX, e.ex);
            chk("posy", PosY, e.ey);
        end
        chk("ready_low_e2", Ready, 0);
        @(posedge Clk); #1;
        chk("moved_one_cycle", Moved, 0);
        chk("ready_after_e3", Ready, 1);
    endtask

    initial begin
        int last_x, last_y, ovr_x;
        vecs.push_back(mk(1, 0, 0, 1, 20, 10, 0, 340, 250, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 255, 245, 0, 595, 5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 35, 0, 0, 630, 5, 0, 0));
`ifdef CURSOR_WRAP_EN
        vecs.push_back(mk(1, 0, 1, 0, 50, 30, 0, 40, 455, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 255, 255, 0, 425, 230, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 255, 215, 0, 170, 445, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 126, 0, 0, 44, 445, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 200, 255, 0, 484, 220, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 146, 0, 0, 630, 220, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 20, 0, 0, 10, 220, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 5, 0, 0, 5, 220, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 10, 0, 0, 635, 220, 0, 0));
        last_x = 635; last_y = 220; ovr_x = 5;
`else
        vecs.push_back(mk(1, 0, 1, 0, 50, 30, 0, 639, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 255, 255, 0, 384, 255, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 255, 215, 0, 129, 470, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 126, 0, 0, 3, 470, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 200, 255, 0, 0, 479, 0, 0));
        last_x = 0; last_y = 479; ovr_x = 10;
`endif
        vecs.push_back(mk(1, 1, 0, 0, 50, 0, 1, last_x, last_y, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, last_x, last_y, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 99, 0, last_x, last_y, 0, 0));

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("rst_posx", PosX, 320);
        chk("rst_posy", PosY, 240);
        chk("rst_ready", Ready, 1);
        chk("rst_moved", Moved, 0);
        chk("rst_overrun", Overrun, 0);
        chk("rst_click_held", ClickHeld, 0);
        chk("rst_click_pulse", ClickPulse, 0);

        // Sensitivity divider instances only see pkt_valid1.
        @(negedge Clk);
        drive(mk(1, 0, 0, 0, 255, 0, 0, 0, 0, 0, 0));
        pkt_valid1 = 1'b1;
        @(negedge Clk);
        pkt_valid1 = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("shift2_posx", PosX1, 383);
        chk("shift7_posx", PosX2, 321);
        chk("shift_main_untouched", PosX, 320);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Second packet lands two cycles after the first and must be dropped.
        chk("overrun_before", Overrun, 0);
        @(negedge Clk);
        drive(mk(1, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
        PktValid = 1'b1;
        @(negedge Clk);
        PktValid = 1'b0;
        @(negedge Clk);
        drive(mk(1, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0));
        PktValid = 1'b1;
        @(posedge Clk); #1;
        chk("overrun_set", Overrun, 1);
        @(negedge Clk);
        PktValid = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        chk("overrun_posx", PosX, ovr_x);
        chk("overrun_sticky", Overrun, 1);
        chk("overrun_ready", Ready, 1);

        // Asynchronous reset while the packet sits in CALC_Y.
        @(negedge Clk);
        drive(mk(1, 0, 0, 1, 40, 40, 1, 0, 0, 0, 0));
        PktValid = 1'b1;
        @(posedge Clk); #1;
        PktValid = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        #1;
        chk("midrst_posx", PosX, 320);
        chk("midrst_posy", PosY, 240);
        chk("midrst_ready", Ready, 1);
        chk("midrst_moved", Moved, 0);
        chk("midrst_overrun", Overrun, 0);
        chk("midrst_held", ClickHeld, 0);
        @(negedge Clk);
        Rst = 1'b0;
        apply(mk(1, 0, 0, 1, 20, 10, 0, 340, 250, 0, 0));
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
